mlp_weight_loader: RTL and testbench

- Streaming weight-load master that drives the accelerator's weight-load port (load_mode/load_addr/load_data/load_valid).
- Accepts a flat word stream from the host DMA over a valid/ready interface.
- Maps each word onto the region/row/col address map in fixed order: L1 weights, L1 bias, L2 weights, L2 bias, proj weights, proj bias.
- Sits between the host DMA and the MLP accelerator. Used before any sample processing and whenever weights are reloaded.

---
 rtl/mlp_weight_loader.sv | 139 +++++++++++++
 tb/tb_mlp_weight_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_weight_loader.sv
// Streaming weight-load master: maps a flat DMA word stream onto the accelerator's
// region/row/col weight-load address map (L1 W/b, L2 W/b, proj W/b).
module mlp_weight_loader #(
    parameter int IN_WIDTH  = 32,
    parameter int L1_ROWS   = 16,
    parameter int L1_COLS   = 63,
    parameter int L2_ROWS   = 16,
    parameter int L2_COLS   = 16,
    parameter int PROJ_ROWS = 4,
    parameter int PROJ_COLS = 43
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic [IN_WIDTH-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_last,
    output logic                load_mode,
    output logic [15:0]         load_addr,
    output logic [IN_WIDTH-1:0] load_data,
    output logic                load_valid,
    output logic [15:0]         words_loaded
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam bit PARAMS_OK =
        (L1_ROWS   >= 1) && (L1_ROWS   <= 16)  && (L1_COLS   >= 1) && (L1_COLS   <= 256) &&
        (L2_ROWS   >= 1) && (L2_ROWS   <= 16)  && (L2_COLS   >= 1) && (L2_COLS   <= 256) &&
        (PROJ_ROWS >= 1) && (PROJ_ROWS <= 16)  && (PROJ_COLS >= 1) && (PROJ_COLS <= 256);

    logic [1:0] state;
    logic [3:0] region;
    logic [3:0] row;
    logic [7:0] col;
    logic [7:0] col_lim;
    logic [3:0] row_lim;
    logic       accept;
    logic       col_end;
    logic       row_end;
    logic       final_word;

    assign busy    = (state == STREAM) || (state == FLUSH);
    assign done    = (state == DONE);
    assign s_ready = (state == STREAM);
    assign accept  = s_valid && s_ready;

    // Bias regions reuse col as the bias index and keep row pinned at 0.
    always_comb begin
        col_lim = 8'(PROJ_ROWS - 1);
        row_lim = 4'h0;
        case (region)
            4'h0: begin col_lim = 8'(L1_COLS - 1);   row_lim = 4'(L1_ROWS - 1);   end
            4'h1: begin col_lim = 8'(L1_ROWS - 1);   row_lim = 4'h0;              end
            4'h2: begin col_lim = 8'(L2_COLS - 1);   row_lim = 4'(L2_ROWS - 1);   end
            4'h3: begin col_lim = 8'(L2_ROWS - 1);   row_lim = 4'h0;              end
            4'h4: begin col_lim = 8'(PROJ_COLS - 1); row_lim = 4'(PROJ_ROWS - 1); end
            default: begin col_lim = 8'(PROJ_ROWS - 1); row_lim = 4'h0;           end
        endcase
    end

    assign col_end    = (col == col_lim);
    assign row_end    = (row == row_lim);
    assign final_word = (region == 4'h5) && col_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            region       <= 4'h0;
            row          <= 4'h0;
            col          <= 8'h00;
            error        <= 1'b0;
            load_mode    <= 1'b0;
            load_addr    <= 16'h0000;
            load_data    <= '0;
            load_valid   <= 1'b0;
            words_loaded <= 16'h0000;
        end else begin
            load_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= STREAM;
                        error        <= 1'b0;
                        words_loaded <= 16'h0000;
                        region       <= 4'h0;
                        row          <= 4'h0;
                        col          <= 8'h00;
                        load_mode    <= 1'b1;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        load_valid <= 1'b1;
                        load_data  <= s_data;
                        load_addr  <= {region, row, col};
                        if (words_loaded != 16'hFFFF)
                            words_loaded <= words_loaded + 16'h0001;
                        if (col_end) begin
                            col <= 8'h00;
                            if (row_end) begin
                                row    <= 4'h0;
                                region <= region + 4'h1;
                            end else begin
                                row <= row + 4'h1;
                            end
                        end else begin
                            col <= col + 8'h01;
                        end
                        // Early s_last or a missing s_last on the final word are both framing errors.
                        if (final_word || s_last) begin
                            state <= FLUSH;
                            if (final_word != s_last)
                                error <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state     <= DONE;
                    load_mode <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        assert (PARAMS_OK) else $error("mlp_weight_loader: parameter out of legal range");
    end

endmodule

// File: tb/tb_mlp_weight_loader.sv
// Directed bench for mlp_weight_loader: full loads, gapped stream, framing errors,
// async reset mid-load and start-during-stream.
module tb_mlp_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, error, s_ready, load_mode, load_valid;
    logic [31:0] s_data, load_data;
    logic        s_valid, s_last;
    logic [15:0] load_addr, words_loaded;

    int checks = 0;
    int errors = 0;

    logic [15:0] addr_log [0:2047];
    int          wr_count = 0;
    int          seq_bad  = 0;
    int          lv_bad   = 0;
    int          mode_bad = 0;
    logic        acc_prev = 1'b0;
    logic [31:0] data_base = 32'h0;

    always #5 clk = ~clk;

    mlp_weight_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .load_mode(load_mode), .load_addr(load_addr), .load_data(load_data),
        .load_valid(load_valid), .words_loaded(words_loaded)
    );

    // Address of stream word n under the default geometry, by plain arithmetic.
    function automatic logic [15:0] exp_addr(input int idx);
        int n;
        n = idx;
        if (n < 1008) return {4'h0, 4'(n / 63), 8'(n % 63)};
        n -= 1008;
        if (n < 16) return {4'h1, 4'h0, 8'(n)};
        n -= 16;
        if (n < 256) return {4'h2, 4'(n / 16), 8'(n % 16)};
        n -= 256;
        if (n < 16) return {4'h3, 4'h0, 8'(n)};
        n -= 16;
        if (n < 172) return {4'h4, 4'(n / 43), 8'(n % 43)};
        n -= 172;
        return {4'h5, 4'h0, 8'(n)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_prev = 1'b0;
            wr_count = 0;
        end else begin
            if (start && !busy) wr_count = 0;
            if (load_valid !== acc_prev) lv_bad++;
            if (load_valid) begin
                if (wr_count < 2048) addr_log[wr_count] = load_addr;
                if (load_addr !== exp_addr(wr_count) || load_data !== data_base + 32'(wr_count))
                    seq_bad++;
                wr_count++;
            end
            if (busy && !load_mode) mode_bad++;
            acc_prev = s_valid && s_ready;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int first, input int count, input int last_at, input bit gaps, input bit hold);
        int cnt;
        for (int i = first; i < first + count; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = data_base + 32'(i);
            s_last  = (i == last_at);
            cnt = 0;
            forever begin
                @(negedge clk);
                if (s_ready) break;
                cnt++;
                if (cnt > 200) break;
            end
            if (cnt > 200) begin
                checks++;
                errors++;
                $error("FAIL send_timeout: observed no s_ready expected s_ready at word %0d", i);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_last = 1'b0;
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic check_end(input string tag, input logic exp_err, input int exp_words);
        @(negedge clk);
        check({tag, "_flush_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_flush_mode"}, 32'(load_mode), 32'd1);
        check({tag, "_flush_lv"}, 32'(load_valid), 32'd1);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_mode"}, 32'(load_mode), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        check({tag, "_wr_count"}, 32'(wr_count), 32'(exp_words));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_mode", 32'(load_mode), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full default load, s_valid held high.
        data_base = 32'h0;
        pulse_start();
        @(negedge clk);
        check("t1_mode", 32'(load_mode), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        send(0, 1472, 1471, 1'b0, 1'b0);
        check_end("t1", 1'b0, 1472);
        check("t1_a0", 32'(addr_log[0]), 32'h0000);
        check("t1_a62", 32'(addr_log[62]), 32'h003E);
        check("t1_a63", 32'(addr_log[63]), 32'h0100);
        check("t1_a1008", 32'(addr_log[1008]), 32'h1000);
        check("t1_a1024", 32'(addr_log[1024]), 32'h2000);
        check("t1_a1296", 32'(addr_log[1296]), 32'h4000);
        check("t1_a1471", 32'(addr_log[1471]), 32'h5003);
        check("t1_seq", 32'(seq_bad), 32'd0);
        check("t1_words_hold", 32'(words_loaded), 32'd1472);

        // Random 50% gaps.
        data_base = 32'h1000_0000;
        pulse_start();
        send(0, 1472, 1471, 1'b1, 1'b0);
        check_end("t2", 1'b0, 1472);
        check("t2_seq", 32'(seq_bad), 32'd0);
        check("t2_lv", 32'(lv_bad), 32'd0);
        check("t2_mode", 32'(mode_bad), 32'd0);

        // Early s_last on word 99.
        data_base = 32'h2000_0000;
        pulse_start();
        send(0, 100, 99, 1'b0, 1'b0);
        check_end("t3", 1'b1, 100);
        check("t3_last_addr", 32'(addr_log[99]), 32'h0124);
        check("t3_error_sticky", 32'(error), 32'd1);

        // New start clears error; a start during STREAM is ignored.
        data_base = 32'h3000_0000;
        pulse_start();
        @(negedge clk);
        check("t6_err_clr", 32'(error), 32'd0);
        @(posedge clk); #1;
        send(0, 300, -1, 1'b0, 1'b0);
        pulse_start();
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_words", 32'(words_loaded), 32'd300);
        @(posedge clk); #1;
        send(300, 1172, 1471, 1'b0, 1'b0);
        check_end("t6", 1'b0, 1472);
        check("t6_seq", 32'(seq_bad), 32'd0);

        // Final word without s_last, s_valid kept high afterwards.
        data_base = 32'h4000_0000;
        pulse_start();
        send(0, 1472, -1, 1'b0, 1'b1);
        check_end("t4", 1'b1, 1472);
        repeat (4) @(negedge clk);
        check("t4_ready_idle", 32'(s_ready), 32'd0);
        check("t4_extra_writes", 32'(wr_count), 32'd1472);
        s_valid = 1'b0;
        @(posedge clk); #1;

        // Async reset after 500 accepts.
        data_base = 32'h5000_0000;
        pulse_start();
        send(0, 500, -1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_lv", 32'(load_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_mode", 32'(load_mode), 32'd0);
        check("t5_addr", 32'(load_addr), 32'd0);
        check("t5_data", load_data, 32'd0);
        check("t5_words", 32'(words_loaded), 32'd0);
        check("t5_ready", 32'(s_ready), 32'd0);
        check("t5_err", 32'(error), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        check("t5_restart_words", 32'(words_loaded), 32'd0);
        @(posedge clk); #1;
        send(0, 5, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t5_restart_a0", 32'(addr_log[0]), 32'h0000);
        check("t5_restart_a4", 32'(addr_log[4]), 32'h0004);
        check("t5_restart_cnt", 32'(wr_count), 32'd5);
        check("t5_seq", 32'(seq_bad), 32'd0);
        check("all_lv", 32'(lv_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
